cmul_seq_ctrl: RTL and testbench

Sequencing controller for the complex multiplier datapath. It accepts one complex operand pair (a, b) over a valid/ready input handshake. It time-shares a single signed DW x DW multiplier across four cycles to form the partial products of a*b, and accumulates the real and imaginary parts. The result is presented over a valid/ready output handshake. It sits between the operand source and the result sink, and is driven by the system clock and async active-low reset.

---
 rtl/cmul_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cmul_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_seq_ctrl.sv
// Sequencing controller for a complex multiply: one shared signed DW x DW
// multiplier is stepped through four partial products per operand pair.
module cmul_seq_ctrl #(
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_ar,
  input  logic signed [DW-1:0] in_ai,
  input  logic signed [DW-1:0] in_br,
  input  logic signed [DW-1:0] in_bi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [2*DW:0] out_re,
  output logic signed [2*DW:0] out_im,
  output logic                 busy,
  output logic [CNTW-1:0]      op_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  ar_q, ai_q, br_q, bi_q;
  logic signed [DW-1:0]  ar_d, ai_d, br_d, bi_d;
  logic signed [2*DW:0]  re_acc_q, re_acc_d;
  logic signed [2*DW:0]  im_acc_q, im_acc_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  out_valid_q;

  logic signed [DW-1:0]   mul_x, mul_y;
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW:0]   prod_ext;
  logic                   accept;

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    unique case (state_q)
      P0:      begin mul_x = ar_q; mul_y = br_q; end
      P1:      begin mul_x = ai_q; mul_y = bi_q; end
      P2:      begin mul_x = ar_q; mul_y = bi_q; end
      P3:      begin mul_x = ai_q; mul_y = br_q; end
      default: ;
    endcase
  end

  assign prod     = (2*DW)'(mul_x) * (2*DW)'(mul_y);
  assign prod_ext = {prod[2*DW-1], prod};

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    ar_d     = ar_q;
    ai_d     = ai_q;
    br_d     = br_q;
    bi_d     = bi_q;
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
    cnt_d    = cnt_q;

    if (accept) begin
      ar_d = in_ar;
      ai_d = in_ai;
      br_d = in_br;
      bi_d = in_bi;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = P0;
      P0: begin
        re_acc_d = prod_ext;
        state_d  = P1;
      end
      P1: begin
        re_acc_d = re_acc_q - prod_ext;
        state_d  = P2;
      end
      P2: begin
        im_acc_d = prod_ext;
        state_d  = P3;
      end
      P3: begin
        im_acc_d = im_acc_q + prod_ext;
        state_d  = DONE;
      end
      DONE: begin
        // A sink handshake can be overlapped with the next operand capture.
        if (out_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = in_valid ? P0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      re_acc_q    <= '0;
      im_acc_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      br_q        <= br_d;
      bi_q        <= bi_d;
      re_acc_q    <= re_acc_d;
      im_acc_q    <= im_acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = re_acc_q;
  assign out_im    = im_acc_q;
  assign busy      = (state_q != IDLE);
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Directed-vector bench for cmul_seq_ctrl with hand-computed complex products.
module tb_cmul_seq_ctrl;

  localparam int DW   = 16;
  localparam int CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_ar, in_ai, in_br, in_bi;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [2*DW:0] out_re, out_im;
  logic                 busy;
  logic [CNTW-1:0]      op_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  bit [CNTW-1:0] exp_cnt = '0;

  cmul_seq_ctrl #(.DW(DW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ar     (in_ar),
    .in_ai     (in_ai),
    .in_br     (in_br),
    .in_bi     (in_bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic signed [DW-1:0] ar, ai, br, bi);
    in_ar = ar;
    in_ai = ai;
    in_br = br;
    in_bi = bi;
  endtask

  // Present one pair with out_ready high; result expected in the 5th cycle
  // after the cycle in which the pair was taken.
  task automatic run_op(input string tag, input logic signed [DW-1:0] ar, ai, br, bi,
                        input longint exp_re, input longint exp_im);
    int c;
    set_ops(ar, ai, br, bi);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    c = 0;
    while (!in_ready && c < 20) begin
      tick();
      c++;
    end
    check_eq({tag, "_rdy"}, longint'(in_ready), 1);
    c = 0;
    do begin
      tick();
      in_valid = 1'b0;
      c++;
    end while (!out_valid && c < 20);
    check_eq({tag, "_lat"}, c, 5);
    check_eq({tag, "_re"}, out_re, exp_re);
    check_eq({tag, "_im"}, out_im, exp_im);
    tick();
    exp_cnt++;
    check_eq({tag, "_cnt"}, op_cnt, longint'(exp_cnt));
    check_eq({tag, "_vld_drop"}, longint'(out_valid), 0);
  endtask

  logic signed [DW-1:0] t_ar [8] = '{16'sd1, 16'sd2, -16'sd1, 16'sd0, 16'sd7, -16'sd3, 16'sd100, 16'sd32767};
  logic signed [DW-1:0] t_ai [8] = '{16'sd1, 16'sd3, 16'sd0, 16'sd1, -16'sd2, -16'sd4, 16'sd200, 16'sd32767};
  logic signed [DW-1:0] t_br [8] = '{16'sd1, 16'sd4, 16'sd5, 16'sd0, 16'sd3, -16'sd3, -16'sd50, 16'sd32767};
  logic signed [DW-1:0] t_bi [8] = '{16'sd1, 16'sd5, -16'sd6, 16'sd1, 16'sd4, 16'sd4, 16'sd10, -16'sd32767};
  longint t_re [8] = '{0, -7, -5, -1, 29, 25, -7000, 2147352578};
  longint t_im [8] = '{2, 22, 6, 0, 22, 0, -9000, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, idx_in, idx_out, last;
    bit fire_in, fire_out;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_ops('0, '0, '0, '0);
    #1;
    check_eq("rst_valid", longint'(out_valid), 0);
    check_eq("rst_re", out_re, 0);
    check_eq("rst_im", out_im, 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_cnt", op_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic and extremes.
    run_op("basic", 16'sd3, 16'sd4, 16'sd1, 16'sd2, -5, 10);
    run_op("ext_a", -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 0, 64'sd2147483648);
    run_op("ext_b", -16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767, 64'sd2147450880, 32768);

    // Back-pressure in DONE with the next pair already waiting.
    set_ops(16'sd3, 16'sd4, 16'sd1, 16'sd2);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    check_eq("bp_lat", c, 4);
    set_ops(16'sd2, -16'sd1, 16'sd2, 16'sd1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_vld", longint'(out_valid), 1);
      check_eq("bp_re", out_re, -5);
      check_eq("bp_im", out_im, 10);
      check_eq("bp_rdy", longint'(in_ready), 0);
      check_eq("bp_cnt", op_cnt, longint'(exp_cnt));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_rdy_rel", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    check_eq("bp_cnt_inc", op_cnt, longint'(exp_cnt));
    check_eq("bp_busy", longint'(busy), 1);
    check_eq("bp_vld_drop", longint'(out_valid), 0);
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    check_eq("bp2_lat", c, 4);
    check_eq("bp2_re", out_re, 5);
    check_eq("bp2_im", out_im, 0);
    tick();
    exp_cnt++;
    check_eq("bp2_cnt", op_cnt, longint'(exp_cnt));

    // Back-to-back stream of 8 pairs.
    idx_in = 0; idx_out = 0; last = 0;
    set_ops(t_ar[0], t_ai[0], t_br[0], t_bi[0]);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && idx_out < 8; cyc++) begin
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        check_eq("b2b_re", out_re, t_re[idx_out]);
        check_eq("b2b_im", out_im, t_im[idx_out]);
        if (idx_out > 0) check_eq("b2b_gap", cyc - last, 5);
        last = cyc;
        idx_out++;
        exp_cnt++;
      end
      tick();
      if (fire_in) begin
        idx_in++;
        if (idx_in < 8) set_ops(t_ar[idx_in], t_ai[idx_in], t_br[idx_in], t_bi[idx_in]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_count", idx_out, 8);
    check_eq("b2b_cnt", op_cnt, longint'(exp_cnt));

    // Asynchronous reset while in P2.
    set_ops(16'sd3, 16'sd4, 16'sd1, 16'sd2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_busy", longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_vld", longint'(out_valid), 0);
    check_eq("mid_busy_clr", longint'(busy), 0);
    check_eq("mid_cnt", op_cnt, 0);
    check_eq("mid_re", out_re, 0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 16'sd2, -16'sd1, 16'sd2, 16'sd1, 5, 0);

    // Counter wrap: 16 more results make 17 since reset.
    for (int i = 0; i < 16; i++)
      run_op("wrap", 16'(i), 16'sd1, 16'sd2, -16'sd1, longint'(2 * i + 1), longint'(2 - i));
    check_eq("wrap_final", op_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
